// File: rtl/register_dump_tx.sv
// Snapshots the register mirror on start, then streams a header byte plus every register (MSB first) to the UART TX.
// First tx_start two cycles after start is accepted; each byte waits for tx_done (3-cycle minimum spacing); done pulses 2 cycles after the final tx_done.
module register_dump_tx #(
  parameter int         NUM_REGS    = 32,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [32*NUM_REGS-1:0]   regs_in,
  input  logic                     tx_done,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEND   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(4 * NUM_REGS);

  logic [1:0]               state_q, state_d;
  logic [7:0]               idx_q, idx_d;
  logic [32*NUM_REGS-1:0]   snap_q, snap_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_start_q, tx_start_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [7:0]               byte_off;
  logic [31:0]              sel_word;
  logic [7:0]               sel_byte;
  logic [7:0]               cur_byte;

  // Byte 0 is the header; byte 1+4k+j is register k, byte j counted from the MSB.
  always_comb begin
    byte_off = idx_q - 8'd1;
    sel_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (byte_off[7:2] == 6'(k)) begin
        sel_word = snap_q[32*k +: 32];
      end
    end
    case (byte_off[1:0])
      2'd0:    sel_byte = sel_word[31:24];
      2'd1:    sel_byte = sel_word[23:16];
      2'd2:    sel_byte = sel_word[15:8];
      default: sel_byte = sel_word[7:0];
    endcase
    cur_byte = (idx_q == 8'd0) ? HEADER_BYTE : sel_byte;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = regs_in;
          idx_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        tx_data_d  = cur_byte;
        tx_start_d = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = S_SEND;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Snapshot contents are meaningless until the next accepted start, so no reset.
  always_ff @(posedge clock) begin
    snap_q <= snap_d;
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/register_dump_tx.md
# register_dump_tx

Debug back-end of the pipeline that consumes the 32 register-file UART mirror outputs. On a start request it snapshots all registers, then streams them byte by byte to the UART transmitter using a start/done handshake. It sits between the register file's debug outputs and the UART TX, so a host can read the complete register state after each step.

## Interface

Parameters:
- NUM_REGS, 32: number of 32-bit registers dumped. Legal range is 1–63, so the 8-bit byte counter never overflows.
- HEADER_BYTE, 8'hA5: sync byte sent before register data.

Ports:
- Clock and reset:
  - clock, input, 1: single clock; all logic rising-edge.
  - reset, input, 1: synchronous, active-high.
- Control:
  - start, input, 1: dump request, level-sampled; acted on only in IDLE.
  - regs_in, input, 32*NUM_REGS: flattened register mirror. Register k occupies bits [32k+31:32k]. The top level concatenates register_k_id_out into this bus.
- UART TX handshake:
  - tx_done, input, 1: one-cycle pulse from UART TX when a byte has fully left the line.
  - tx_data, output, 8: byte to transmit; stable from tx_start until the next tx_start.
  - tx_start, output, 1: one-cycle pulse requesting transmission of tx_data.
- Status:
  - busy, output, 1: high from acceptance of start until the cycle done pulses.
  - done, output, 1: one-cycle pulse after the last byte's tx_done.

## Operation

- States are IDLE, SEND, WAIT, FINISH.
- Stream content:
  - Total length is 1 + 4*NUM_REGS bytes (129 by default).
  - Byte 0 is HEADER_BYTE.
  - Byte 1+4k+j is register k, bits [31-8j : 24-8j]. Registers are sent in order 0 upward, each most-significant byte first.
- IDLE:
  - When start is sampled high: copy all of regs_in into an internal snapshot, clear byte index to 0, set busy=1, go to SEND.
  - Otherwise stay in IDLE.
- SEND: drive tx_data = byte[index] and tx_start=1, then go to WAIT.
- WAIT:
  - Hold tx_start=0.
  - On tx_done=1 with index = last: go to FINISH.
  - On tx_done=1 with any other index: increment index and go to SEND.
- FINISH: set done=1 and busy=0, then go to IDLE.
- Boundary conditions:
  - All transmitted bytes come from the snapshot. Changes on regs_in after acceptance do not affect the current dump.
  - start while busy is ignored; no queuing.
  - tx_done outside WAIT is ignored. This covers a stale done after a mid-dump reset.
  - If start is still high when the FSM returns to IDLE, a new dump begins. This is legal continuous-dump mode.
  - Reset mid-dump: state returns to IDLE and all outputs are cleared at that edge. Snapshot contents become don't-care. The next start restarts from the header.
- Arithmetic: the byte index is 8 bits unsigned, and "last" = 4*NUM_REGS. Register values are sent raw, so negative values appear in two's complement.

## Timing

- Reset values: tx_data=8'h00, tx_start=0, busy=0, done=0, state=IDLE, index=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Start to first byte: start sampled at edge N. busy=1 after edge N. tx_start=1 after edge N+1 and lasts exactly one cycle.
- Byte to byte: tx_done sampled at edge M. The next tx_start is high after edge M+1. The minimum spacing between tx_start pulses is 3 cycles, reached when tx_done returns the cycle after tx_start.
- End of dump: the final tx_done is sampled at edge M. done=1 and busy=0 after edge M+1, lasting one cycle. A start can be accepted at edge M+2 at the earliest.
- Total dump latency is 129 × (UART byte time + 2) + 3 cycles.

## Test plan

- Reset: hold reset for 3 cycles with start=1 and tx_done toggling. Required: tx_start, busy and done stay 0 throughout, and tx_data=00.
- Full dump with default register values r1=10, r3=15, r5=-5, r16=AAAAAAAA. The UART model returns tx_done 10 cycles after each tx_start. Required:
  - exactly 129 tx_start pulses;
  - the stream starts A5, 00 00 00 00, 00 00 00 0A;
  - bytes 21–24 are FF FF FF FB;
  - bytes 65–68 are AA AA AA AA;
  - one done pulse, with busy low after it.
- Snapshot: change regs_in register 1 to 32'h12345678 right after start is accepted. Required: bytes 5–8 are still 00 00 00 0A.
- Ignored events: pulse start during the dump, and pulse tx_done while in SEND or IDLE. Required: no extra or missing bytes, and the byte count stays 129.
- Reset after the 40th byte, followed by a late tx_done, then a new start. Required: the late tx_done is ignored, and the new stream begins with A5 followed by register 0.
- Fast UART: tx_done one cycle after each tx_start. Required: tx_start pulses exactly 3 cycles apart, and done follows 2 cycles after the final tx_done.
